// File: rtl/t05_find_least.sv
// ---------------------------------------------------------------------------
// t05_find_least
//
// Scans the 256-entry character histogram in SRAM in ascending address order
// and reports the two least-frequent non-zero characters with their counts.
// The Huffman tree builder uses this pair to merge nodes. A one-cycle start
// pulse begins the scan. The block drives the SRAM port only while busy.
//
// Parameters
//   SRAM_LAT    cycles from the read-issue cycle until sram_in is valid (>= 1)
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        begin a scan (sampled only while idle)
//   sram_in      SRAM read data
//   hist_addr    SRAM address
//   sram_out     SRAM write data (always zero)
//   wr_r_en      SRAM command: 0 = read, 1 = write, 3 = idle
//   least1_char  address of the smallest non-zero count
//   least1_cnt   count of least1_char
//   least2_char  address of the second-smallest non-zero count
//   least2_cnt   count of least2_char
//   nonzero      number of non-zero entries seen so far (0..256)
//   err          fewer than two non-zero entries were found
//   busy         high from ISSUE through DONE
//   done         one-cycle completion pulse
//
// Optional feature (macro T05_FIND_LEAST_ZERO_OUT_EN)
//   When defined, the scan is followed by two write slots that clear the
//   histogram entries of the two minima. A later run then yields the next
//   pair of minima. A slot whose minimum is empty still takes one cycle but
//   issues no write. Without the macro the block never writes.
// ---------------------------------------------------------------------------
module t05_find_least #(
  parameter int SRAM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sram_in,
  output logic [7:0]  hist_addr,
  output logic [31:0] sram_out,
  output logic [1:0]  wr_r_en,
  output logic [7:0]  least1_char,
  output logic [31:0] least1_cnt,
  output logic [7:0]  least2_char,
  output logic [31:0] least2_cnt,
  output logic [8:0]  nonzero,
  output logic        err,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_IDLE  = 2'd3;

  // WAIT lasts SRAM_LAT-1 cycles. The counter runs 0..SRAM_LAT-2.
  localparam int WAIT_W = (SRAM_LAT > 2) ? $clog2(SRAM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (SRAM_LAT > 1) ? WAIT_W'(SRAM_LAT - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
`ifdef T05_FIND_LEAST_ZERO_OUT_EN
    S_ZERO1,
    S_ZERO2,
`endif
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        idx;
  logic [WAIT_W-1:0] wait_cnt;

  // Working minima. The valid flags mark a slot that holds an entry.
  logic [7:0]  min1_char, min2_char;
  logic [31:0] min1_cnt,  min2_cnt;
  logic        min1_vld,  min2_vld;

  logic [7:0]  min1_char_nxt, min2_char_nxt;
  logic [31:0] min1_cnt_nxt,  min2_cnt_nxt;
  logic        min1_vld_nxt,  min2_vld_nxt;
  logic [8:0]  nonzero_nxt;

  // Count sampled in COMPARE.
  logic [31:0] cnt_p0;

  // Strict unsigned ordering. On equal counts the entry already held (lower
  // address, since the scan ascends) keeps its slot.
  function automatic logic is_less(input logic [31:0] a, input logic [31:0] b);
    return a < b;
  endfunction

  assign cnt_p0   = sram_in;
  assign sram_out = 32'd0;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next state and SRAM command ----
  always_comb begin
    state_nxt = state;
    hist_addr = 8'd0;
    wr_r_en   = CMD_IDLE;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        hist_addr = idx;
        wr_r_en   = CMD_READ;
        if (SRAM_LAT > 1) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_COMPARE;
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (idx == 8'hFF) begin
`ifdef T05_FIND_LEAST_ZERO_OUT_EN
          state_nxt = S_ZERO1;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_ISSUE;
        end
      end
`ifdef T05_FIND_LEAST_ZERO_OUT_EN
      S_ZERO1: begin
        if (min1_vld) begin
          hist_addr = min1_char;
          wr_r_en   = CMD_WRITE;
        end
        state_nxt = S_ZERO2;
      end
      S_ZERO2: begin
        if (min2_vld) begin
          hist_addr = min2_char;
          wr_r_en   = CMD_WRITE;
        end
        state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- minima update ----
  always_comb begin
    min1_char_nxt = min1_char;
    min1_cnt_nxt  = min1_cnt;
    min1_vld_nxt  = min1_vld;
    min2_char_nxt = min2_char;
    min2_cnt_nxt  = min2_cnt;
    min2_vld_nxt  = min2_vld;
    nonzero_nxt   = nonzero;
    if (state == S_IDLE && start) begin
      min1_char_nxt = 8'd0;
      min1_cnt_nxt  = 32'd0;
      min1_vld_nxt  = 1'b0;
      min2_char_nxt = 8'd0;
      min2_cnt_nxt  = 32'd0;
      min2_vld_nxt  = 1'b0;
      nonzero_nxt   = 9'd0;
    end else if (state == S_COMPARE && cnt_p0 != 32'd0) begin
      nonzero_nxt = nonzero + 9'd1;
      if (!min1_vld || is_less(cnt_p0, min1_cnt)) begin
        // New smallest: the old smallest slides down to second place.
        min2_char_nxt = min1_char;
        min2_cnt_nxt  = min1_cnt;
        min2_vld_nxt  = min1_vld;
        min1_char_nxt = idx;
        min1_cnt_nxt  = cnt_p0;
        min1_vld_nxt  = 1'b1;
      end else if (!min2_vld || is_less(cnt_p0, min2_cnt)) begin
        min2_char_nxt = idx;
        min2_cnt_nxt  = cnt_p0;
        min2_vld_nxt  = 1'b1;
      end
    end
  end

  // ---- control and result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= 8'd0;
      wait_cnt    <= '0;
      min1_vld    <= 1'b0;
      min2_vld    <= 1'b0;
      nonzero     <= 9'd0;
      err         <= 1'b0;
      least1_char <= 8'd0;
      least1_cnt  <= 32'd0;
      least2_char <= 8'd0;
      least2_cnt  <= 32'd0;
    end else begin
      min1_vld <= min1_vld_nxt;
      min2_vld <= min2_vld_nxt;
      nonzero  <= nonzero_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx         <= 8'd0;
            err         <= 1'b0;
            least1_char <= 8'd0;
            least1_cnt  <= 32'd0;
            least2_char <= 8'd0;
            least2_cnt  <= 32'd0;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_COMPARE: begin
          if (idx != 8'hFF) begin
            idx <= idx + 8'd1;
          end
        end
        default: begin
        end
      endcase
      // Results appear together with the done pulse. They are taken from the
      // post-update minima because the final COMPARE may still change them.
      if (state_nxt == S_DONE) begin
        least1_char <= min1_char_nxt;
        least1_cnt  <= min1_cnt_nxt;
        least2_char <= min2_char_nxt;
        least2_cnt  <= min2_cnt_nxt;
        err         <= (nonzero_nxt < 9'd2);
      end
    end
  end

  // ---- working minima data ----
  always_ff @(posedge clk) begin
    min1_char <= min1_char_nxt;
    min1_cnt  <= min1_cnt_nxt;
    min2_char <= min2_char_nxt;
    min2_cnt  <= min2_cnt_nxt;
  end

endmodule

// File: tb/tb_t05_find_least.sv
`timescale 1ns/1ps
module tb_t05_find_least;

  localparam int LAT = 2;
  localparam int PER = LAT + 1;
`ifdef T05_FIND_LEAST_ZERO_OUT_EN
  localparam int DONE_REL = 256 * PER + 3;
`else
  localparam int DONE_REL = 256 * PER + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] sram_in;
  logic [7:0]  hist_addr;
  logic [31:0] sram_out;
  logic [1:0]  wr_r_en;
  logic [7:0]  least1_char;
  logic [31:0] least1_cnt;
  logic [7:0]  least2_char;
  logic [31:0] least2_cnt;
  logic [8:0]  nonzero;
  logic        err;
  logic        busy;
  logic        done;

  t05_find_least #(.SRAM_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sram_in    (sram_in),
    .hist_addr  (hist_addr),
    .sram_out   (sram_out),
    .wr_r_en    (wr_r_en),
    .least1_char(least1_char),
    .least1_cnt (least1_cnt),
    .least2_char(least2_char),
    .least2_cnt (least2_cnt),
    .nonzero    (nonzero),
    .err        (err),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered read with LAT cycles of latency, write-through.
  logic [31:0] mem     [256];
  logic [31:0] ds      [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_pipe [LAT];
  int load_gen = 0;
  int load_seen = 0;

  always @(posedge clk) begin
    if (load_gen != load_seen) begin
      for (int a = 0; a < 256; a++) mem[a] <= ds[a];
      load_seen <= load_gen;
    end else if (wr_r_en == 2'd1) begin
      mem[hist_addr] <= sram_out;
    end
    rd_pipe[0] <= (wr_r_en == 2'd0) ? mem[hist_addr] : 32'hDEAD_BEEF;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign sram_in = rd_pipe[LAT-1];

  typedef struct {
    logic [7:0]  c1;
    logic [31:0] n1;
    logic [7:0]  c2;
    logic [31:0] n2;
    logic [8:0]  nz;
    logic        err;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic [7:0] addr;
    int         cyc;
  } wr_t;

  exp_t sb[$];
  wr_t  wq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: samples 1ns after each rising edge.
  logic mon_rst;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  int   rd_idx = 0;
  int   base_cyc = 0;

  always @(posedge clk) begin
    exp_t e;
    wr_t  w;
    mon_rst = rst;
    #1;
    if (mon_rst) begin
      chk("reset_state",
          {least1_char, least1_cnt, least2_char, least2_cnt, nonzero, err, busy, done, wr_r_en, hist_addr, sram_out},
          {8'd0, 32'd0, 8'd0, 32'd0, 9'd0, 1'b0, 1'b0, 1'b0, 2'd3, 8'd0, 32'd0});
    end else begin
      if (busy && !prev_busy) begin
        base_cyc = cyc - 1;
        rd_idx   = 0;
      end
      chk("sram_out_zero", sram_out, 32'd0);
      if (wr_r_en == 2'd2) chk("cmd_legal", wr_r_en, 2'd3);
      if (wr_r_en == 2'd0) begin
        chk("read_trace", {hist_addr, cyc - base_cyc}, {rd_idx[7:0], 1 + rd_idx * PER});
        rd_idx++;
      end
      if (wr_r_en == 2'd1) begin
        if (wq.size() == 0) begin
          chk("write_unexpected", wq.size(), 1);
        end else begin
          w = wq.pop_front();
          chk("write", {hist_addr, cyc}, {w.addr, w.cyc});
        end
      end
      if (done) begin
        chk("done_width", prev_done, 1'b0);
        if (sb.size() == 0) begin
          chk("done_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("least1", {least1_char, least1_cnt}, {e.c1, e.n1});
          chk("least2", {least2_char, least2_cnt}, {e.c2, e.n2});
          chk("nonzero", nonzero, e.nz);
          chk("err", err, e.err);
          chk("writes_pending", wq.size(), 0);
        end
      end
      if (sb.size() > 0 && cyc > sb[0].done_cyc + 4) begin
        chk("done_missing", cyc, sb[0].done_cyc);
        e = sb.pop_front();
      end
    end
    prev_busy = busy;
    prev_done = done;
  end

  task automatic clear_ds();
    for (int a = 0; a < 256; a++) ds[a] = 32'd0;
  endtask

  task automatic random_ds();
    for (int a = 0; a < 256; a++) begin
      if ($urandom_range(0, 7) == 0)
        ds[a] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(1, 12);
      else
        ds[a] = 32'd0;
    end
  endtask

  task automatic load();
    for (int a = 0; a < 256; a++) ref_mem[a] = ds[a];
    load_gen++;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Reference: sort all non-zero (count, address) pairs; the two smallest
  // keys are the answer (count first, lower address breaks ties).
  task automatic run(input bit abort, input bit repulse);
    logic [39:0] q[$];
    logic [39:0] k;
    exp_t e;
    wr_t  w;
    int   c0;
    int   n;
    for (int a = 0; a < 256; a++)
      if (ref_mem[a] != 32'd0) q.push_back({ref_mem[a], 8'(a)});
    q.sort();
    e.c1 = 8'd0; e.n1 = 32'd0; e.c2 = 8'd0; e.n2 = 32'd0;
    if (q.size() > 0) begin k = q[0]; e.c1 = k[7:0]; e.n1 = k[39:8]; end
    if (q.size() > 1) begin k = q[1]; e.c2 = k[7:0]; e.n2 = k[39:8]; end
    e.nz  = 9'(q.size());
    e.err = (q.size() < 2);
    @(negedge clk);
    c0 = cyc;
    e.done_cyc = c0 + DONE_REL;
    start = 1'b1;
    if (!abort) begin
      sb.push_back(e);
`ifdef T05_FIND_LEAST_ZERO_OUT_EN
      if (q.size() > 0) begin
        w.addr = e.c1; w.cyc = c0 + 256 * PER + 1; wq.push_back(w);
        ref_mem[e.c1] = 32'd0;
      end
      if (q.size() > 1) begin
        w.addr = e.c2; w.cyc = c0 + 256 * PER + 2; wq.push_back(w);
        ref_mem[e.c2] = 32'd0;
      end
`endif
    end
    @(negedge clk);
    start = 1'b0;
    if (abort) begin
      // COMPARE of idx 100
      while (cyc < c0 + PER * 101) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end else begin
      if (repulse) begin
        while (cyc < c0 + 300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      n = 0;
      while (!(sb.size() == 0 && !busy) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 5000) begin
        $display("FAIL run_timeout actual=busy required=idle");
        $fatal(1, "scan did not complete");
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    clear_ds();
    load();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic dataset, then a second run on the resulting memory.
    clear_ds();
    ds[8'h41] = 32'd5; ds[8'h42] = 32'd3; ds[8'h43] = 32'd9;
    load();
    run(1'b0, 1'b0);
    run(1'b0, 1'b0);

    // Ties resolve to the lower address.
    clear_ds();
    ds[8'h10] = 32'd4; ds[8'h20] = 32'd4; ds[8'h30] = 32'd4;
    load();
    run(1'b0, 1'b0);

    // Single entry at the top address.
    clear_ds();
    ds[8'hFF] = 32'd7;
    load();
    run(1'b0, 1'b0);

    // All zero.
    clear_ds();
    load();
    run(1'b0, 1'b0);

    // Reset mid-scan, then a clean run on the same data.
    random_ds();
    load();
    run(1'b1, 1'b0);
    run(1'b0, 1'b0);

    // Start re-pulsed while busy.
    random_ds();
    load();
    run(1'b0, 1'b1);

    // Random datasets, including counts with the top bit set.
    for (int r = 0; r < 3; r++) begin
      random_ds();
      ds[$urandom_range(0, 255)] = 32'h8000_0001;
      load();
      run(1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
